// File: rtl/sd_rx_fifo_pk.sv
// sd_rx_fifo_pk: single-clock SD receive FIFO. Serial lanes of 1, 4 or 8 bits
// are packed MSB-first into OUT_W-bit words. The words go into a DEPTH-entry
// first-word-fall-through buffer, which reports its level, an almost-full
// watermark and sticky overflow/underflow flags. A synchronous flush is provided.
`timescale 1ns/1ps
module sd_rx_fifo_pk #(
  parameter int MAX_IN_W = 8,
  parameter int OUT_W    = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [1:0]               bus_width,
  input  logic [MAX_IN_W-1:0]      d,
  input  logic                     wr,
  input  logic                     rd,
  output logic [OUT_W-1:0]         q,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     partial,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int BCW = $clog2(OUT_W) + 1;

  typedef enum logic [1:0] {
    LANE1 = 2'b00,
    LANE4 = 2'b01,
    LANE8 = 2'b10
  } lane_e;

  // The reserved encoding 2'b11 behaves as a 4-bit lane.
  function automatic lane_e norm_mode(input logic [1:0] bw);
    case (bw)
      2'b00:   norm_mode = LANE1;
      2'b10:   norm_mode = LANE8;
      default: norm_mode = LANE4;
    endcase
  endfunction

  function automatic logic [BCW-1:0] lane_width(input lane_e m);
    case (m)
      LANE1:   lane_width = BCW'(1);
      LANE8:   lane_width = BCW'(8);
      default: lane_width = BCW'(4);
    endcase
  endfunction

  // Packer state
  lane_e              mode_q, mode_d, cur_mode;
  logic [OUT_W-1:0]   sh_q, sh_d;
  logic [BCW-1:0]     bitcnt_q, bitcnt_d;
  logic [BCW-1:0]     lw;
  logic [BCW:0]       cnt_sum;
  logic [OUT_W-1:0]   lane_ext;
  logic [OUT_W-1:0]   word;
  logic               word_done;

  // Buffer state
  logic [OUT_W-1:0]   mem [DEPTH];
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               pop_ok;
  logic               push_ok;
  logic               drop;
  logic               rd_empty;

  // Packer: choose the lane (latched at word start), shift it in, detect completion
  always_comb begin
    cur_mode  = (bitcnt_q == '0) ? norm_mode(bus_width) : mode_q;
    lw        = lane_width(cur_mode);
    case (cur_mode)
      LANE1:   lane_ext = OUT_W'(d[0]);
      LANE8:   lane_ext = OUT_W'(d[7:0]);
      default: lane_ext = OUT_W'(d[3:0]);
    endcase
    word      = (sh_q << lw) | lane_ext;
    cnt_sum   = {1'b0, bitcnt_q} + {1'b0, lw};
    word_done = wr && (cnt_sum == (BCW+1)'(OUT_W));
    sh_d      = sh_q;
    bitcnt_d  = bitcnt_q;
    mode_d    = mode_q;
    if (wr) begin
      mode_d = cur_mode;
      if (word_done) begin
        sh_d     = '0;
        bitcnt_d = '0;
      end else begin
        sh_d     = word;
        bitcnt_d = cnt_sum[BCW-1:0];
      end
    end
  end

  // Buffer control: pop/push qualification, pointers, level and sticky flags
  always_comb begin
    pop_ok   = rd && (level_q != '0);
    rd_empty = rd && (level_q == '0);
    // A pop in the same cycle frees a slot, so a push at full still lands.
    push_ok  = word_done && ((level_q != LW'(DEPTH)) || pop_ok);
    drop     = word_done && !push_ok;
    wptr_d   = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d   = pop_ok  ? rptr_q + 1'b1 : rptr_q;
    level_d  = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    ovf_d    = ovf_q | drop;
    unf_d    = unf_q | rd_empty;
  end

  // Control and packer registers: async reset, flush overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= LANE1;
      sh_q     <= '0;
      bitcnt_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (flush) begin
      mode_q   <= LANE1;
      sh_q     <= '0;
      bitcnt_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Word storage: a plain register file with no reset; the level counter qualifies its contents
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wptr_q] <= word;
    end
  end

  // Status outputs come straight from the registered level; q reads zero while empty
  always_comb begin
    empty       = (level_q == '0);
    full        = (level_q == LW'(DEPTH));
    almost_full = (level_q >= LW'(AF_LEVEL));
    level       = level_q;
    partial     = (bitcnt_q != '0);
    overflow    = ovf_q;
    underflow   = unf_q;
    q           = empty ? '0 : mem[rptr_q];
  end

endmodule

// File: tb/tb_sd_rx_fifo_pk.sv
// Testbench for sd_rx_fifo_pk: a table of 4-bit packing vectors, directed
// corner-case sequences and randomized traffic, all compared against a
// queue-based reference model.
`timescale 1ns/1ps
module tb_sd_rx_fifo_pk;

  localparam int OUT_W = 32;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  bus_width = 2'b00;
  logic [7:0]  d = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] q;
  logic        empty, full, almost_full, partial, overflow, underflow;
  logic [4:0]  level;

  int nchecks = 0;
  int nerr = 0;

  sd_rx_fifo_pk #(.MAX_IN_W(8), .OUT_W(OUT_W), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus_width(bus_width), .d(d),
    .wr(wr), .rd(rd), .q(q), .empty(empty), .full(full),
    .almost_full(almost_full), .level(level), .partial(partial),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  // Reference model: stored words in a queue, the packer as a bit count plus accumulator
  logic [31:0] mq[$];
  int          mbits = 0;
  logic [63:0] macc = '0;
  int          mlat = 1;
  bit          mov = 0;
  bit          mun = 0;

  task automatic model_clear();
    mq.delete();
    mbits = 0;
    macc  = '0;
    mov   = 0;
    mun   = 0;
  endtask

  task automatic model_step(input bit w, input bit r, input bit f,
                            input logic [1:0] bw, input logic [7:0] dd);
    int old, mask;
    bit pop, done;
    logic [31:0] wd;
    if (f) begin
      model_clear();
      return;
    end
    old  = mq.size();
    pop  = r && (old > 0);
    if (r && old == 0) mun = 1;
    done = 0;
    wd   = '0;
    if (w) begin
      if (mbits == 0) mlat = (bw == 2'b00) ? 1 : (bw == 2'b10) ? 8 : 4;
      mask  = (1 << mlat) - 1;
      macc  = (macc << mlat) | 64'(int'(dd) & mask);
      mbits = mbits + mlat;
      if (mbits == OUT_W) begin
        done  = 1;
        wd    = macc[31:0];
        mbits = 0;
        macc  = '0;
      end
    end
    if (pop) void'(mq.pop_front());
    if (done) begin
      if (old < DEPTH || pop) mq.push_back(wd);
      else mov = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] eq;
    eq = (mq.size() > 0) ? mq[0] : 32'h0;
    chk("q", 64'(q), 64'(eq));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("almost_full", 64'(almost_full), 64'(mq.size() >= AFL));
    chk("level", 64'(level), 64'(mq.size()));
    chk("partial", 64'(partial), 64'(mbits != 0));
    chk("overflow", 64'(overflow), 64'(mov));
    chk("underflow", 64'(underflow), 64'(mun));
  endtask

  // One clock: drive, advance model, sample 1ns after the edge
  task automatic cyc(input bit w, input bit r, input bit f,
                     input logic [1:0] bw, input logic [7:0] dd);
    wr = w; rd = r; flush = f; bus_width = bw; d = dd;
    model_step(w, r, f, bw, dd);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 2'b00, 8'h00);
  endtask

  task automatic push8(input logic [31:0] w, input bit rd_first, input bit rd_last);
    for (int i = 0; i < 4; i++)
      cyc(1, (i == 0 && rd_first) || (i == 3 && rd_last), 0, 2'b10, w[31-8*i -: 8]);
  endtask

  task automatic push_nib(input logic [31:0] w);
    for (int i = 0; i < 8; i++)
      cyc(1, 0, 0, 2'b01, {4'($urandom), w[31-4*i -: 4]});
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  bw;
    logic [7:0]  d;
    logic [31:0] eq;
    bit          ee;
    int          el;
    bit          ep;
  } vec_t;

  vec_t tbl[8];

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i].wr = 1;
      tbl[i].bw = 2'b01;
      tbl[i].d  = 8'(i + 1);
      tbl[i].eq = (i == 7) ? 32'h12345678 : 32'h0;
      tbl[i].ee = (i != 7);
      tbl[i].el = (i == 7) ? 1 : 0;
      tbl[i].ep = (i != 7);
    end

    // Reset state
    model_clear();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // 4-bit packing from the vector table
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].wr, 0, 0, tbl[i].bw, tbl[i].d);
      chk("tbl_q", 64'(q), 64'(tbl[i].eq));
      chk("tbl_empty", 64'(empty), 64'(tbl[i].ee));
      chk("tbl_level", 64'(level), 64'(tbl[i].el));
      chk("tbl_partial", 64'(partial), 64'(tbl[i].ep));
    end
    cyc(0, 1, 0, 2'b00, 8'h00);

    // 1-bit mode MSB-first with junk on the unused lines, then 8-bit mode
    begin
      logic [31:0] pat;
      pat = 32'hA5C3_0F1E;
      for (int i = 0; i < 32; i++)
        cyc(1, 0, 0, 2'b00, {7'($urandom), pat[31-i]});
      chk("lane1_word", 64'(q), 64'h0000_0000_A5C3_0F1E);
      push8(32'hDEADBEEF, 0, 0);
      chk("lane8_level", 64'(level), 64'd2);
      cyc(0, 1, 0, 2'b00, 8'h00);
      chk("lane8_word", 64'(q), 64'h0000_0000_DEAD_BEEF);
      cyc(0, 1, 0, 2'b00, 8'h00);
      chk("drained", 64'(empty), 64'd1);
    end

    // Fill, overflow, drain, underflow
    for (int k = 0; k < DEPTH; k++) begin
      push8(32'(k), 0, 0);
      if (k == AFL - 2) chk("af_below", 64'(almost_full), 64'd0);
      if (k == AFL - 1) chk("af_at", 64'(almost_full), 64'd1);
    end
    chk("full_at16", 64'(full), 64'd1);
    push8(32'h99, 0, 0);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_level", 64'(level), 64'd16);
    for (int k = 0; k < DEPTH; k++) begin
      chk("fill_pop", 64'(q), 64'(k));
      cyc(0, 1, 0, 2'b00, 8'h00);
    end
    chk("fill_empty", 64'(empty), 64'd1);
    cyc(0, 1, 0, 2'b00, 8'h00);
    chk("unf_set", 64'(underflow), 64'd1);
    cyc(0, 0, 1, 2'b00, 8'h00);

    // Wrap: 40 words, level kept within 4..5 by interleaved pops
    begin
      int nxt;
      nxt = 0;
      for (int k = 0; k < 5; k++) push8(32'h100 + 32'(k), 0, 0);
      for (int k = 5; k < 40; k++) begin
        chk("wrap_order", 64'(q), 64'(32'h100 + 32'(nxt)));
        push8(32'h100 + 32'(k), 1, 0);
        nxt++;
      end
      for (int k = 0; k < 5; k++) begin
        chk("wrap_order", 64'(q), 64'(32'h100 + 32'(nxt)));
        cyc(0, 1, 0, 2'b00, 8'h00);
        nxt++;
      end
      chk("wrap_flags", 64'({overflow, underflow, empty}), 64'b001);
    end

    // Full push+pop on the same cycle
    for (int k = 0; k < DEPTH; k++) push8(32'h200 + 32'(k), 0, 0);
    push8(32'hCAFEF00D, 0, 1);
    chk("fpp_level", 64'(level), 64'd16);
    chk("fpp_ovf", 64'(overflow), 64'd0);
    for (int k = 1; k < DEPTH; k++) begin
      chk("fpp_order", 64'(q), 64'(32'h200 + 32'(k)));
      cyc(0, 1, 0, 2'b00, 8'h00);
    end
    chk("fpp_last", 64'(q), 64'h0000_0000_CAFE_F00D);
    cyc(0, 1, 0, 2'b00, 8'h00);

    // Asynchronous reset mid-operation
    for (int k = 0; k < 5; k++) push8(32'h300 + 32'(k), 0, 0);
    cyc(1, 0, 0, 2'b01, 8'h0A);
    cyc(1, 0, 0, 2'b01, 8'h0B);
    chk("pre_rst_partial", 64'(partial), 64'd1);
    chk("pre_rst_level", 64'(level), 64'd5);
    wr = 0; rd = 0; flush = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    push_nib(32'h12345678);
    chk("post_rst_word", 64'(q), 64'h0000_0000_1234_5678);
    cyc(0, 1, 0, 2'b00, 8'h00);

    // Flush mid-operation, with wr and rd also asserted
    for (int k = 0; k < 5; k++) push8(32'h400 + 32'(k), 0, 0);
    cyc(1, 0, 0, 2'b01, 8'h0C);
    chk("pre_fl_partial", 64'(partial), 64'd1);
    cyc(1, 1, 1, 2'b01, 8'h0D);
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_partial", 64'(partial), 64'd0);
    push_nib(32'h9ABCDEF0);
    chk("post_fl_word", 64'(q), 64'h0000_0000_9ABC_DEF0);
    cyc(0, 1, 0, 2'b00, 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
          $urandom_range(0, 299) == 0, 2'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
